// File: rtl/clk_period_mon.sv
// clk_period_mon
//   Samples an asynchronous periodic signal in the clk domain and measures its
//   high time, low time and period in clk cycles. Flags periods outside
//   [MIN_PERIOD, MAX_PERIOD] and reports loss of activity as a timeout.
//
// Ports
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   en          measurement enable (synchronous to clk)
//   mon_in      monitored signal, asynchronous to clk
//   meas_valid  one-cycle pulse: high_cnt/low_cnt/period_cnt/period_err updated
//   high_cnt    clk cycles mon_in was high in the last full period
//   low_cnt     clk cycles mon_in was low in the last full period
//   period_cnt  high_cnt + low_cnt, saturating
//   period_err  period out of legal range, qualified by meas_valid
//   timeout     one-cycle pulse: awaited edge missing for TIMEOUT cycles
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | disabled, counters cleared
// WAIT_RISE | enabled, discarding partial period until the first rise
// MEAS_HIGH | counting high cycles, waiting for fall
// MEAS_LOW  | counting low cycles, waiting for the closing rise

module clk_period_mon #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PERIOD  = 4,
  parameter int MAX_PERIOD  = 1000,
  parameter int TIMEOUT     = 2000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mon_in,
  output logic             meas_valid,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             period_err,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  // Timer is a down-counter; reaching zero on the TIMEOUT-th cycle in a state.
  localparam logic [CNT_W-1:0] TMR_LOAD = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] MIN_P    = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] MAX_P    = CNT_W'(MAX_PERIOD);

  typedef enum logic [1:0] {IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   s, rise, fall;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d, tmr_q, tmr_d;
  logic             pub_d, pub_q, to_d;
  logic [CNT_W-1:0] pub_h_q, pub_l_q, pub_p_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], mon_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev_q;
  assign fall = ~s & prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      lcnt_q  <= '0;
      tmr_q   <= TMR_LOAD;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      lcnt_q  <= lcnt_d;
      tmr_q   <= tmr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    lcnt_d  = lcnt_q;
    tmr_d   = tmr_q;
    pub_d   = 1'b0;
    to_d    = 1'b0;
    if (!en) begin
      state_d = IDLE;
      hcnt_d  = '0;
      lcnt_d  = '0;
      tmr_d   = TMR_LOAD;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT_RISE;
          hcnt_d  = '0;
          lcnt_d  = '0;
          tmr_d   = TMR_LOAD;
        end
        WAIT_RISE: begin
          // Edge takes priority over an expiring timer.
          if (rise) begin
            state_d = MEAS_HIGH;
            hcnt_d  = CNT_W'(1);
            lcnt_d  = '0;
            tmr_d   = TMR_LOAD;
          end else if (tmr_q == '0) begin
            to_d   = 1'b1;
            hcnt_d = '0;
            lcnt_d = '0;
            tmr_d  = TMR_LOAD;
          end else begin
            tmr_d = tmr_q - CNT_W'(1);
          end
        end
        MEAS_HIGH: begin
          if (fall) begin
            state_d = MEAS_LOW;
            lcnt_d  = CNT_W'(1);
            tmr_d   = TMR_LOAD;
          end else if (tmr_q == '0) begin
            to_d    = 1'b1;
            state_d = WAIT_RISE;
            hcnt_d  = '0;
            lcnt_d  = '0;
            tmr_d   = TMR_LOAD;
          end else begin
            hcnt_d = sat_inc(hcnt_q);
            tmr_d  = tmr_q - CNT_W'(1);
          end
        end
        MEAS_LOW: begin
          if (rise) begin
            pub_d   = 1'b1;
            state_d = MEAS_HIGH;
            hcnt_d  = CNT_W'(1);
            lcnt_d  = '0;
            tmr_d   = TMR_LOAD;
          end else if (tmr_q == '0) begin
            to_d    = 1'b1;
            state_d = WAIT_RISE;
            hcnt_d  = '0;
            lcnt_d  = '0;
            tmr_d   = TMR_LOAD;
          end else begin
            lcnt_d = sat_inc(lcnt_q);
            tmr_d  = tmr_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Closing rise snapshots the counts; outputs update one cycle later because
  // the counters themselves restart on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pub_q   <= 1'b0;
      pub_h_q <= '0;
      pub_l_q <= '0;
      pub_p_q <= '0;
    end else begin
      pub_q <= pub_d;
      if (pub_d) begin
        pub_h_q <= hcnt_q;
        pub_l_q <= lcnt_q;
        pub_p_q <= sat_add(hcnt_q, lcnt_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meas_valid <= 1'b0;
      high_cnt   <= '0;
      low_cnt    <= '0;
      period_cnt <= '0;
      period_err <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= pub_q;
      timeout    <= to_d;
      if (pub_q) begin
        high_cnt   <= pub_h_q;
        low_cnt    <= pub_l_q;
        period_cnt <= pub_p_q;
        period_err <= (pub_p_q < MIN_P) || (pub_p_q > MAX_P);
      end
    end
  end

endmodule
